// File: rtl/exec_stage_flex_if.sv
// Handshake and bus bundle between the decoder, exec_stage_flex and the mem/writeback stages.
// The master side is the upstream decoder plus downstream consumer; the slave side is the stage.
interface exec_stage_flex_if #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [2:0]            in_op;
   logic [DATA_W-1:0]     in_a;
   logic [DATA_W-1:0]     in_b;
   logic [2:0]            in_cond;
   logic                  in_flag_we;
   logic [1:0]            in_reg_we;
   logic [REG_ADDR_W-1:0] in_reg_dest;
   logic                  in_set_pc;
   logic [1:0]            in_mem_read;
   logic [1:0]            in_mem_write;
   logic [DATA_W-1:0]     in_mem_addr;
   logic [DATA_W-1:0]     in_pc;
   logic [DATA_W-1:0]     in_imm;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     out_data;
   logic [DATA_W-1:0]     out_mem_addr;
   logic [DATA_W-1:0]     out_pc;
   logic [DATA_W-1:0]     out_imm;
   logic [1:0]            out_reg_we;
   logic [REG_ADDR_W-1:0] out_reg_dest;
   logic                  out_set_pc;
   logic [1:0]            out_mem_read;
   logic [1:0]            out_mem_write;
   logic                  mem_op_next;
   logic [3:0]            status_flags;

   modport master (
      output in_valid, in_op, in_a, in_b, in_cond, in_flag_we, in_reg_we, in_reg_dest,
             in_set_pc, in_mem_read, in_mem_write, in_mem_addr, in_pc, in_imm, out_ready,
      input  in_ready, out_valid, out_data, out_mem_addr, out_pc, out_imm, out_reg_we,
             out_reg_dest, out_set_pc, out_mem_read, out_mem_write, mem_op_next, status_flags
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_cond, in_flag_we, in_reg_we, in_reg_dest,
             in_set_pc, in_mem_read, in_mem_write, in_mem_addr, in_pc, in_imm, out_ready,
      output in_ready, out_valid, out_data, out_mem_addr, out_pc, out_imm, out_reg_we,
             out_reg_dest, out_set_pc, out_mem_read, out_mem_write, mem_op_next, status_flags
   );
endinterface

// File: rtl/exec_stage_flex.sv
// Execute stage with valid/ready handshakes, condition-gated side effects and {Z,C,N,V} flags.
// Define EXEC_STAGE_MUL_EN to build the multi-cycle shift-add multiplier for op 7; otherwise op 7 is a NOP.
//
// state  | meaning
// S_IDLE | accepting instructions, single-cycle ops complete on the accept edge
// S_MUL  | shift-add multiply in progress, then wait for downstream room to publish the result
module exec_stage_flex #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 4,
   parameter int MUL_CNT_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   exec_stage_flex_if.slave bus
);

   if (DATA_W < 8) begin : g_bad_data_w
      $error("exec_stage_flex: DATA_W must be at least 8");
   end
   if ((2 ** MUL_CNT_W) <= DATA_W) begin : g_bad_cnt_w
      $error("exec_stage_flex: MUL_CNT_W too narrow for DATA_W steps");
   end

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef struct packed {
      logic [1:0]            reg_we;
      logic [REG_ADDR_W-1:0] reg_dest;
      logic                  set_pc;
      logic [1:0]            mem_read;
      logic [1:0]            mem_write;
      logic [DATA_W-1:0]     mem_addr;
      logic [DATA_W-1:0]     pc;
      logic [DATA_W-1:0]     imm;
   } side_t;

   function automatic side_t gate_side(input side_t s, input logic ok);
      side_t g;
      g = s;
      if (!ok) begin
         g.reg_we    = '0;
         g.set_pc    = 1'b0;
         g.mem_read  = '0;
         g.mem_write = '0;
      end
      return g;
   endfunction

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   side_t             side_q, side_d;
   logic [3:0]        flags_q, flags_d;

   side_t             in_side;
   logic              accept;
   logic              cond_ok;
   logic              op_is_mul;
   logic              out_room;

   logic [DATA_W:0]   add_full;
   logic [DATA_W:0]   sub_full;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c;
   logic              alu_v;

   assign in_side.reg_we    = bus.in_reg_we;
   assign in_side.reg_dest  = bus.in_reg_dest;
   assign in_side.set_pc    = bus.in_set_pc;
   assign in_side.mem_read  = bus.in_mem_read;
   assign in_side.mem_write = bus.in_mem_write;
   assign in_side.mem_addr  = bus.in_mem_addr;
   assign in_side.pc        = bus.in_pc;
   assign in_side.imm       = bus.in_imm;

   assign op_is_mul = (bus.in_op == OP_MUL);
   assign out_room  = !valid_q || bus.out_ready;

`ifdef EXEC_STAGE_MUL_EN
   typedef enum logic {S_IDLE, S_MUL} state_t;
   localparam logic [MUL_CNT_W-1:0] MUL_STEPS = MUL_CNT_W'(DATA_W);

   state_t                  state_q, state_d;
   logic [MUL_CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*DATA_W-1:0]     mcand_q, mcand_d;
   logic [DATA_W-1:0]       mplier_q, mplier_d;
   logic [2*DATA_W-1:0]     acc_q, acc_d;
   side_t                   m_side_q, m_side_d;
   logic                    m_ok_q, m_ok_d;
   logic                    m_fwe_q, m_fwe_d;

   assign bus.in_ready = (state_q == S_IDLE) && out_room;
`else
   assign bus.in_ready = out_room;
`endif

   assign accept          = bus.in_valid && bus.in_ready;
   assign bus.mem_op_next = bus.in_valid && (bus.in_mem_read[0] || bus.in_mem_write[0]);

   // Flags are {Z,C,N,V}; the condition always sees the value before this instruction's update.
   always_comb begin
      cond_ok = 1'b0;
      case (bus.in_cond)
         3'd0:    cond_ok = 1'b1;
         3'd1:    cond_ok = flags_q[3];
         3'd2:    cond_ok = !flags_q[3];
         3'd3:    cond_ok = flags_q[2];
         3'd4:    cond_ok = !flags_q[2];
         3'd5:    cond_ok = flags_q[1];
         3'd6:    cond_ok = flags_q[0];
         default: cond_ok = 1'b0;
      endcase
   end

   always_comb begin
      add_full = {1'b0, bus.in_a} + {1'b0, bus.in_b};
      sub_full = {1'b0, bus.in_a} + {1'b0, ~bus.in_b} + (DATA_W+1)'(1);
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      case (bus.in_op)
         OP_ADD: begin
            alu_res = add_full[DATA_W-1:0];
            alu_c   = add_full[DATA_W];
            alu_v   = (bus.in_a[DATA_W-1] == bus.in_b[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != bus.in_a[DATA_W-1]);
         end
         OP_SUB: begin
            alu_res = sub_full[DATA_W-1:0];
            alu_c   = sub_full[DATA_W];
            alu_v   = (bus.in_a[DATA_W-1] != bus.in_b[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != bus.in_a[DATA_W-1]);
         end
         OP_AND: alu_res = bus.in_a & bus.in_b;
         OP_OR:  alu_res = bus.in_a | bus.in_b;
         OP_XOR: alu_res = bus.in_a ^ bus.in_b;
         OP_SHL: begin
            alu_res = {bus.in_a[DATA_W-2:0], 1'b0};
            alu_c   = bus.in_a[DATA_W-1];
         end
         OP_SHR: begin
            alu_res = {1'b0, bus.in_a[DATA_W-1:1]};
            alu_c   = bus.in_a[0];
         end
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      side_d  = side_q;
      flags_d = flags_q;
      if (valid_q && bus.out_ready) valid_d = 1'b0;

`ifdef EXEC_STAGE_MUL_EN
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      m_side_d = m_side_q;
      m_ok_d   = m_ok_q;
      m_fwe_d  = m_fwe_q;

      if (accept && !op_is_mul) begin
`else
      if (accept) begin
`endif
         // Without the multiplier, op 7 lands here with a zero result and no side effects.
         valid_d = 1'b1;
         data_d  = alu_res;
         side_d  = gate_side(in_side, cond_ok && !op_is_mul);
         if (cond_ok && bus.in_flag_we && !op_is_mul)
            flags_d = {(alu_res == '0), alu_c, alu_res[DATA_W-1], alu_v};
      end

`ifdef EXEC_STAGE_MUL_EN
      case (state_q)
         S_IDLE: begin
            if (accept && op_is_mul) begin
               state_d  = S_MUL;
               cnt_d    = '0;
               mcand_d  = {{DATA_W{1'b0}}, bus.in_a};
               mplier_d = bus.in_b;
               acc_d    = '0;
               m_side_d = in_side;
               m_ok_d   = cond_ok;
               m_fwe_d  = bus.in_flag_we;
            end
         end
         S_MUL: begin
            if (cnt_q != MUL_STEPS) begin
               if (mplier_q[0]) acc_d = acc_q + mcand_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 1'b1;
            end else if (out_room) begin
               // Publish only once the previous result has been taken.
               state_d = S_IDLE;
               valid_d = 1'b1;
               data_d  = acc_q[DATA_W-1:0];
               side_d  = gate_side(m_side_q, m_ok_q);
               if (m_ok_q && m_fwe_q)
                  flags_d = {(acc_q[DATA_W-1:0] == '0), |acc_q[2*DATA_W-1:DATA_W],
                             acc_q[DATA_W-1], 1'b0};
            end
         end
         default: state_d = S_IDLE;
      endcase
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         side_q   <= '0;
         flags_q  <= '0;
`ifdef EXEC_STAGE_MUL_EN
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         m_side_q <= '0;
         m_ok_q   <= 1'b0;
         m_fwe_q  <= 1'b0;
`endif
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         side_q   <= side_d;
         flags_q  <= flags_d;
`ifdef EXEC_STAGE_MUL_EN
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         m_side_q <= m_side_d;
         m_ok_q   <= m_ok_d;
         m_fwe_q  <= m_fwe_d;
`endif
      end
   end

   assign bus.out_valid     = valid_q;
   assign bus.out_data      = data_q;
   assign bus.out_reg_we    = side_q.reg_we;
   assign bus.out_reg_dest  = side_q.reg_dest;
   assign bus.out_set_pc    = side_q.set_pc;
   assign bus.out_mem_read  = side_q.mem_read;
   assign bus.out_mem_write = side_q.mem_write;
   assign bus.out_mem_addr  = side_q.mem_addr;
   assign bus.out_pc        = side_q.pc;
   assign bus.out_imm       = side_q.imm;
   assign bus.status_flags  = flags_q;

endmodule

// File: tb/tb_exec_stage_flex.sv
// Directed bench for exec_stage_flex: vector table for single-cycle ops plus stall, multiply and reset sequences.
module tb_exec_stage_flex;

   localparam int DW = 16;
   localparam int RW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   exec_stage_flex_if #(.DATA_W(DW), .REG_ADDR_W(RW)) bus ();

   exec_stage_flex #(.DATA_W(DW), .REG_ADDR_W(RW), .MUL_CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  cond;
      logic        fw;
      logic [1:0]  reg_we;
      logic [1:0]  mem_wr;
      logic [15:0] exp_data;
      logic [3:0]  exp_flags;
      logic [1:0]  exp_reg_we;
      logic [1:0]  exp_mem_wr;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] cond, input logic fw, input logic [1:0] reg_we,
                        input logic [1:0] mem_wr, input logic [15:0] pc);
      bus.in_valid     = 1'b1;
      bus.in_op        = op;
      bus.in_a         = a;
      bus.in_b         = b;
      bus.in_cond      = cond;
      bus.in_flag_we   = fw;
      bus.in_reg_we    = reg_we;
      bus.in_mem_write = mem_wr;
      bus.in_pc        = pc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      bit  ready_low;
      bit  late;
      logic [15:0] held;

      bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
      bus.in_cond = '0; bus.in_flag_we = 1'b0; bus.in_reg_we = '0; bus.in_reg_dest = 4'd5;
      bus.in_set_pc = 1'b0; bus.in_mem_read = '0; bus.in_mem_write = '0;
      bus.in_mem_addr = 16'h0040; bus.in_pc = '0; bus.in_imm = 16'h00AA; bus.out_ready = 1'b1;

      //                 op    a        b        cond fw reg   mw     data     flags    reg   mw
      vecs.push_back('{3'd0, 16'hFFFF, 16'h0001, 3'd0, 1, 2'b01, 2'b00, 16'h0000, 4'b1100, 2'b01, 2'b00});
      vecs.push_back('{3'd0, 16'h0001, 16'h0002, 3'd1, 0, 2'b11, 2'b11, 16'h0003, 4'b1100, 2'b11, 2'b11});
      vecs.push_back('{3'd0, 16'h0001, 16'h0002, 3'd2, 1, 2'b11, 2'b11, 16'h0003, 4'b1100, 2'b00, 2'b00});
      vecs.push_back('{3'd1, 16'h7FFF, 16'hFFFF, 3'd0, 1, 2'b11, 2'b00, 16'h8000, 4'b0011, 2'b11, 2'b00});
      vecs.push_back('{3'd2, 16'hF0F0, 16'h0FF0, 3'd5, 1, 2'b11, 2'b01, 16'h00F0, 4'b0000, 2'b11, 2'b01});
      vecs.push_back('{3'd3, 16'h1234, 16'h4321, 3'd5, 1, 2'b11, 2'b01, 16'h5335, 4'b0000, 2'b00, 2'b00});
      vecs.push_back('{3'd4, 16'hAAAA, 16'hAAAA, 3'd0, 1, 2'b10, 2'b00, 16'h0000, 4'b1000, 2'b10, 2'b00});
      vecs.push_back('{3'd5, 16'h8001, 16'h0000, 3'd0, 1, 2'b00, 2'b00, 16'h0002, 4'b0100, 2'b00, 2'b00});
      vecs.push_back('{3'd6, 16'h0003, 16'h0000, 3'd3, 1, 2'b11, 2'b00, 16'h0001, 4'b0100, 2'b11, 2'b00});
      vecs.push_back('{3'd0, 16'h0001, 16'h0001, 3'd4, 1, 2'b11, 2'b11, 16'h0002, 4'b0100, 2'b00, 2'b00});
      vecs.push_back('{3'd0, 16'h0005, 16'h0005, 3'd7, 1, 2'b11, 2'b11, 16'h000A, 4'b0100, 2'b00, 2'b00});
      vecs.push_back('{3'd1, 16'h0005, 16'h0005, 3'd0, 1, 2'b00, 2'b00, 16'h0000, 4'b1100, 2'b00, 2'b00});
      vecs.push_back('{3'd1, 16'h0000, 16'h0001, 3'd0, 1, 2'b00, 2'b00, 16'hFFFF, 4'b0010, 2'b00, 2'b00});
      vecs.push_back('{3'd0, 16'h7FFF, 16'h0001, 3'd6, 1, 2'b11, 2'b00, 16'h8000, 4'b0010, 2'b00, 2'b00});
      vecs.push_back('{3'd0, 16'h7FFF, 16'h0001, 3'd0, 1, 2'b00, 2'b00, 16'h8000, 4'b0011, 2'b00, 2'b00});
`ifndef EXEC_STAGE_MUL_EN
      vecs.push_back('{3'd7, 16'h0003, 16'h0004, 3'd0, 1, 2'b11, 2'b11, 16'h0000, 4'b0011, 2'b00, 2'b00});
`endif
      vecs.push_back('{3'd2, 16'hFFFF, 16'h00FF, 3'd6, 0, 2'b11, 2'b00, 16'h00FF, 4'b0011, 2'b11, 2'b00});

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst flags", 32'(bus.status_flags), 32'd0);
      chk("rst out_data", 32'(bus.out_data), 32'd0);
      chk("rst out_reg_we", 32'(bus.out_reg_we), 32'd0);
      chk("rst in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      bus.in_valid = 1'b1;
      bus.in_mem_read = 2'b01;
      #1;
      chk("mem_op_next", 32'(bus.mem_op_next), 32'd1);
      bus.in_valid = 1'b0;
      #1;
      chk("mem_op_next idle", 32'(bus.mem_op_next), 32'd0);
      bus.in_mem_read = 2'b00;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cond, vecs[i].fw,
               vecs[i].reg_we, vecs[i].mem_wr, 16'(16'h0100 + i));
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'd1);
         chk($sformatf("v%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
         chk($sformatf("v%0d flags", i), 32'(bus.status_flags), 32'(vecs[i].exp_flags));
         chk($sformatf("v%0d out_reg_we", i), 32'(bus.out_reg_we), 32'(vecs[i].exp_reg_we));
         chk($sformatf("v%0d out_mem_write", i), 32'(bus.out_mem_write), 32'(vecs[i].exp_mem_wr));
         chk($sformatf("v%0d out_pc", i), 32'(bus.out_pc), 32'(16'h0100 + i));
      end
      chk("passthrough imm", 32'(bus.out_imm), 32'h00AA);
      chk("passthrough reg_dest", 32'(bus.out_reg_dest), 32'd5);

      // Downstream stall with three back-to-back ADDs
      @(negedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(3'd0, 16'd1, 16'd1, 3'd0, 1'b0, 2'b01, 2'b00, 16'h0);
      @(posedge clk);
      #1;
      chk("stall first valid", 32'(bus.out_valid), 32'd1);
      chk("stall first data", 32'(bus.out_data), 32'd2);
      chk("stall in_ready low", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      drive(3'd0, 16'd2, 16'd2, 3'd0, 1'b0, 2'b01, 2'b00, 16'h0);
      held = bus.out_data;
      repeat (3) @(posedge clk);
      #1;
      chk("stall hold data", 32'(bus.out_data), 32'(held));
      chk("stall hold ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stall second data", 32'(bus.out_data), 32'd4);
      @(negedge clk);
      drive(3'd0, 16'd3, 16'd3, 3'd0, 1'b0, 2'b01, 2'b00, 16'h0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("stall third data", 32'(bus.out_data), 32'd6);
      chk("stall third valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
      chk("stall drained", 32'(bus.out_valid), 32'd0);

`ifdef EXEC_STAGE_MUL_EN
      // 0x0123 * 0x0010
      @(negedge clk);
      drive(3'd7, 16'h0123, 16'h0010, 3'd0, 1'b1, 2'b11, 2'b00, 16'h0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      ready_low = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = k;
            break;
         end
         if (bus.in_ready) ready_low = 1'b0;
      end
      chk("mul1 latency", 32'(lat), 32'd17);
      chk("mul1 in_ready low", 32'(ready_low), 32'd1);
      chk("mul1 data", 32'(bus.out_data), 32'h1230);
      chk("mul1 flags", 32'(bus.status_flags), 32'b0000);
      chk("mul1 reg_we", 32'(bus.out_reg_we), 32'b11);

      // 0x8000 * 0x0002
      @(negedge clk);
      drive(3'd7, 16'h8000, 16'h0002, 3'd0, 1'b1, 2'b01, 2'b00, 16'h0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = k;
            break;
         end
      end
      chk("mul2 latency", 32'(lat), 32'd17);
      chk("mul2 data", 32'(bus.out_data), 32'h0000);
      chk("mul2 flags", 32'(bus.status_flags), 32'b1100);

      // Reset five cycles into a multiply
      @(negedge clk);
      drive(3'd7, 16'h0003, 16'h0005, 3'd0, 1'b1, 2'b11, 2'b00, 16'h0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mulrst out_valid", 32'(bus.out_valid), 32'd0);
      chk("mulrst flags", 32'(bus.status_flags), 32'd0);
      chk("mulrst in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      late = 1'b0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) late = 1'b1;
      end
      chk("mulrst no late result", 32'(late), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/exec_stage_flex.md
Name: exec_stage_flex

Overview:
- Parametrised successor to the single-cycle execute stage.
- Sits between the decoder and the memory/writeback stages.
- Adds three things the current stage lacks:
  - valid/ready handshakes on both sides.
  - A 4-flag status register (Z,C,N,V) that is written only when the instruction requests it.
  - A multi-cycle shift-add multiplier (optional).
- Width and register-address size are generic. Condition evaluation gates every side effect.

Parameters:
- DATA_W, 16, datapath/address width (>=8).
- REG_ADDR_W, 4, width of the destination register index.
- MUL_CNT_W, 5, width of the multiplier iteration counter; must satisfy 2**MUL_CNT_W > DATA_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- in_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, 7 MUL.
- in_a, in_b  in  DATA_W  operands, already source-selected upstream.
- in_cond  in  3  0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 V, 7 never.
- in_flag_we  in  1  update flags with this result.
- in_reg_we  in  2  {high byte, low byte} register write request.
- in_reg_dest  in  REG_ADDR_W  destination register.
- in_set_pc  in  1  result goes to PC.
- in_mem_read, in_mem_write  in  2  {1=word/0=byte, enable}.
- in_mem_addr, in_pc, in_imm  in  DATA_W  passthrough.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data, out_mem_addr, out_pc, out_imm  out  DATA_W  registered results/passthroughs.
- out_reg_we  out  2  gated register write.
- out_reg_dest  out  REG_ADDR_W  destination register.
- out_set_pc  out  1  gated PC write.
- out_mem_read, out_mem_write  out  2  gated memory requests.
- mem_op_next  out  1  combinational: in_valid & (in_mem_read[0] | in_mem_write[0]).
- status_flags  out  4  {Z,C,N,V}, registered.

Behaviour:
- Reset: all out_* = 0, out_valid = 0, status_flags = 0, FSM = IDLE, counter = 0.
- Accept rule: accept = in_valid & in_ready.
  - in_ready = (state==IDLE) & (!out_valid | out_ready).
- Condition:
  - cond_ok is evaluated at accept against status_flags before this instruction's update.
  - If !cond_ok: out_reg_we, out_set_pc, out_mem_read and out_mem_write are forced to 0, and flags are not written.
  - out_data is still produced.
- Single-cycle ops: result registered on the accept edge; out_valid high the following cycle (latency 1).
  - Flags are written on the same edge, so the next accepted instruction sees them.
- Flag rules, all widths DATA_W; Z = result==0 and N = result[DATA_W-1] for every op:
  - ADD: C = carry out; V = signed overflow.
  - SUB (a-b): computed as a + ~b + 1; C = carry out, i.e. 1 = no borrow; V = signed overflow.
  - AND/OR/XOR: C = 0, V = 0.
  - SHL1: C = a[DATA_W-1]; V = 0.
  - SHR1 (logical): C = a[0]; V = 0.
- Output holding: while out_valid & !out_ready, every out_* holds stable.
  - If out_ready is high in the cycle a new result is loaded, the new result replaces the old (full throughput).
- FSM IDLE/MUL (op 7):
  - On accept: go to MUL; latch operands, condition result, sideband fields and counter = 0.
  - Each MUL cycle: one shift-add step, counter increments.
  - After DATA_W steps: load low DATA_W bits into out_data and write flags (if enabled): Z, N; C = |high half; V = 0. Return to IDLE.
  - out_valid rises DATA_W+1 cycles after the accept edge. in_ready is low throughout MUL.
  - Downstream stall at completion: the FSM waits in MUL with the result held, until !out_valid | out_ready.
- Reset mid-MUL: aborts; no output produced; flags return to 0.
- No simultaneous flag writers: only one instruction is in flight in the ALU.

Optional Feature:
- Macro: EXEC_STAGE_MUL_EN.
- Defined: MUL FSM and counter are present as above.
- Undefined:
  - FSM logic is removed and the stage is always IDLE.
  - op 7 behaves as a NOP: latency 1, out_data = 0, all gated side-effect outputs 0, flags unchanged.

Test Plan:
- ADD 0xFFFF+0x0001, flag_we=1, cond=0 -> next cycle out_data=0x0000, status_flags=4'b1100.
- SUB 0x7FFF-0xFFFF, flag_we=1 -> out_data=0x8000, flags Z=0 C=0 N=1 V=1.
- After ADD test: cond=1 (Z), reg_we=2'b11, mem_write=2'b11 -> outputs 2'b11/2'b11. Same instruction with cond=2 -> both 0, out_valid=1, flags unchanged.
- out_ready=0 with 3 back-to-back ADDs -> first result held stable, in_ready=0 after first. Raise out_ready -> remaining two emerge in order, one per cycle.
- MUL_EN: 0x0123*0x0010 -> out_data=0x1230, C=0, out_valid 17 cycles after accept, in_ready low meanwhile. 0x8000*0x0002 -> 0x0000, Z=1, C=1.
- rst asserted 5 cycles into MUL -> next cycle out_valid=0, status_flags=0, in_ready=1, and no late result.
